// File: rtl/ub_banked_read_port.sv
// ub_banked_read_port: walks a 2-D scan, issues banked reads to a 4-bank
// unified buffer and returns pixels in x-fastest order on a valid/ready stream.
// Ports: clk, rst_n, flush, start | read_ren, read_ctrl_vars, bank_ren,
//        bank_raddr, bank_rdata | out_data, out_valid, out_ready, done, err.
// Option: define UB_READ_ADDR_CHECK_EN to flag and zero-fill reads whose
//         untruncated address is >= DEPTH (err is sticky); otherwise err=0.
module ub_banked_read_port #(
  parameter int WIDTH       = 16,
  parameter int EXT_X       = 64,
  parameter int EXT_Y       = 64,
  parameter int STRIDE_Y    = 64,
  parameter int DEPTH       = 4096,
  parameter int START_DELAY = 0,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 start,
  output logic                 read_ren,
  output logic [3*WIDTH-1:0]   read_ctrl_vars,
  output logic [3:0]           bank_ren,
  output logic [AW-1:0]        bank_raddr,
  input  logic [4*WIDTH-1:0]   bank_rdata,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 done,
  output logic                 err
);

  localparam int AAW   = WIDTH + AW;
  localparam int DLAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;
  localparam int DW    = (DLAST < 2) ? 1 : $clog2(DLAST + 1);

  localparam logic [WIDTH-1:0] X_LAST   = WIDTH'(EXT_X - 1);
  localparam logic [WIDTH-1:0] Y_LAST   = WIDTH'(EXT_Y - 1);
  localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);
  localparam logic [AAW-1:0]   STRIDE_W = AAW'(STRIDE_Y);
  localparam logic [DW-1:0]    D_LAST   = DW'(DLAST);
  localparam logic [DW-1:0]    D_ONE    = DW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [DW-1:0]    dcnt;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [1:0]       cnt;
  logic             infl;
  logic [1:0]       reg_bank;
  logic             reg_zero;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [WIDTH-1:0] mem [2];
  logic             err_q;

  logic [AAW-1:0]   addr_full;
  logic [1:0]       bank_idx;
  logic             oor;
  logic             pop;
  logic [2:0]       occ;
  logic             issue;
  logic             last_pt;
  logic [WIDTH-1:0] push_data;

  assign addr_full = {{AW{1'b0}}, x}
                   + STRIDE_W * {{AW{1'b0}}, y};
  assign bank_idx  = {y[0], x[0]};
  assign last_pt   = (x == X_LAST) && (y == Y_LAST);

`ifdef UB_READ_ADDR_CHECK_EN
  assign oor = addr_full >= AAW'(DEPTH);
`else
  logic unused_hi;
  assign unused_hi = ^addr_full[AAW-1:AW];
  assign oor = 1'b0;
`endif

  // An entry popped this cycle counts as free, so a full pipe
  // (one buffered, one in flight) still sustains one pixel per cycle.
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign occ       = {1'b0, cnt} + {2'b0, infl} - {2'b0, pop};
  assign issue     = (state == S_RUN) && (occ < 3'd2);

  assign read_ren       = issue;
  assign read_ctrl_vars = issue ? {y, x, {WIDTH{1'b0}}} : '0;
  assign bank_raddr     = issue ? addr_full[AW-1:0] : '0;
  assign bank_ren       = (issue && !oor) ? (4'b0001 << bank_idx) : 4'b0;

  assign push_data = reg_zero ? '0
                   : bank_rdata[reg_bank*WIDTH +: WIDTH];
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dcnt     <= '0;
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      infl     <= 1'b0;
      reg_bank <= '0;
      reg_zero <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      done     <= 1'b0;
      err_q    <= 1'b0;
    end else if (flush) begin
      state    <= S_IDLE;
      dcnt     <= '0;
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      infl     <= 1'b0;
      reg_zero <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            dcnt  <= '0;
            state <= (START_DELAY == 0) ? S_RUN : S_DELAY;
          end
        end
        S_DELAY: begin
          if (dcnt == D_LAST) state <= S_RUN;
          else dcnt <= dcnt + D_ONE;
        end
        S_RUN: begin
          if (issue && last_pt) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (cnt == 2'd0 && !infl) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + W_ONE;
        end else begin
          x <= x + W_ONE;
        end
        reg_bank <= bank_idx;
        reg_zero <= oor;
        if (oor) err_q <= 1'b1;
      end
      infl <= issue;

      if (infl) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, infl} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ub_banked_read_port.sv
// tb_ub_banked_read_port: directed bench for ub_banked_read_port.
// Three instances: default 64x64, small delayed 4x2, and stride-128.
module tb_ub_banked_read_port;

`ifdef UB_READ_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic start = 1'b0;
  logic start3 = 1'b0;
  logic start5 = 1'b0;
  logic out_ready = 1'b1;
  logic tog = 1'b0;

  always #5 clk = ~clk;

  logic        read_ren, out_valid, done, err;
  logic [47:0] cv;
  logic [3:0]  bren;
  logic [11:0] raddr;
  logic [63:0] rdata = '0;
  logic [15:0] od;

  logic        read_ren3, ov3, done3, err3;
  logic [47:0] cv3;
  logic [3:0]  bren3;
  logic [11:0] raddr3;
  logic [63:0] rdata3 = '0;
  logic [15:0] od3;

  logic        read_ren5, ov5, done5, err5;
  logic [47:0] cv5;
  logic [3:0]  bren5;
  logic [11:0] raddr5;
  logic [63:0] rdata5 = '0;
  logic [15:0] od5;

  ub_banked_read_port u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
    .read_ren(read_ren), .read_ctrl_vars(cv), .bank_ren(bren),
    .bank_raddr(raddr), .bank_rdata(rdata), .out_data(od),
    .out_valid(out_valid), .out_ready(out_ready), .done(done), .err(err)
  );

  ub_banked_read_port #(.EXT_X(4), .EXT_Y(2), .START_DELAY(5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .start(start3),
    .read_ren(read_ren3), .read_ctrl_vars(cv3), .bank_ren(bren3),
    .bank_raddr(raddr3), .bank_rdata(rdata3), .out_data(od3),
    .out_valid(ov3), .out_ready(1'b1), .done(done3), .err(err3)
  );

  ub_banked_read_port #(.STRIDE_Y(128)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .start(start5),
    .read_ren(read_ren5), .read_ctrl_vars(cv5), .bank_ren(bren5),
    .bank_raddr(raddr5), .bank_rdata(rdata5), .out_data(od5),
    .out_valid(ov5), .out_ready(1'b1), .done(done5), .err(err5)
  );

  function automatic logic [15:0] pat(input int b, input int a);
    return 16'(b * 16384 + 8192 + (a % 4096));
  endfunction

  function automatic logic [15:0] exp_px(input int idx, input int ex,
                                         input int st, input bit ck);
    int x, y, a, b;
    x = idx % ex;
    y = idx / ex;
    a = x + st * y;
    b = (x % 2) + 2 * (y % 2);
    if (ck && a >= 4096) return 16'd0;
    return pat(b, a);
  endfunction

  // bank models: synchronous read, one cycle after bank_ren
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bren[b])  rdata[b*16 +: 16]  <= pat(b, int'(raddr));
      if (bren3[b]) rdata3[b*16 +: 16] <= pat(b, int'(raddr3));
      if (bren5[b]) rdata5[b*16 +: 16] <= pat(b, int'(raddr5));
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = tog ? ~out_ready : 1'b1;
  end

  logic mon_clr = 1'b0;
  int pix = 0, bad = 0, done_n = 0, hold_bad = 0;
  int iss = 0, acc = 0, max_out = 0, done_at = 0;
  logic pv = 1'b0;
  logic [15:0] pd = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      pix = 0; bad = 0; done_n = 0; hold_bad = 0;
      iss = 0; acc = 0; max_out = 0; pv = 1'b0;
    end else if (rst_n) begin
      if (pv && !(out_valid && od == pd)) hold_bad++;
      pv = out_valid && !out_ready;
      pd = od;
      if (read_ren) iss++;
      if (out_valid && out_ready) begin
        if (od !== exp_px(pix, 64, 64, 1'b0)) bad++;
        pix++;
        acc++;
      end
      if (iss - acc > max_out) max_out = iss - acc;
      if (done) begin
        done_n++;
        done_at = cyc;
      end
    end
  end

  int pix5 = 0, bad5 = 0, done5_n = 0;
  logic err_seen = 1'b0;
  logic [47:0] last_cv = '0, err_cv = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (err5 && !err_seen) begin
        err_seen = 1'b1;
        err_cv = last_cv;
      end
      if (read_ren5) last_cv = cv5;
      if (ov5) begin
        if (od5 !== exp_px(pix5, 64, 128, CHK)) bad5++;
        pix5++;
      end
      if (done5) done5_n++;
    end
  end

  task automatic clr_mon();
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_for(input string tag, input int sel, input int lim);
    int n;
    n = 0;
    while (((sel == 0) ? done_n : done5_n) == 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 64'(n < lim), 64'd1);
  endtask

  int c0, first, first_ov, nout, bad3, done3_n, done_k, p0;
  logic [31:0] seq;

  initial begin
    #1;
    chk("rst_outs", {read_ren, bren, out_valid, done, err}, 0);
    chk("rst_data", {od, raddr, cv}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T1 + T5: full sweeps, default and stride-128 instances together
    clr_mon();
    @(negedge clk);
    start = 1'b1;
    start5 = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b0;
    start5 = 1'b0;
    chk("t1_iss0", {read_ren, bren, raddr}, {1'b1, 4'b0001, 12'd0});
    chk("t1_cv0", cv, 48'd0);
    chk("t1_ov0", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_iss1", {read_ren, bren, raddr}, {1'b1, 4'b0010, 12'd1});
    chk("t1_cv1", cv, {16'd0, 16'd1, 16'd0});
    chk("t1_ov1", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_first", {out_valid, od}, {1'b1, pat(0, 0)});
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_for("t1_done_to", 0, 6000);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_count", pix, 4096);
    chk("t1_bad", bad, 0);
    chk("t1_done_n", done_n, 1);
    chk("t1_done_cyc", done_at - c0, 4099);
    chk("t1_idle", {out_valid, read_ren}, 0);
    chk("t1_err", err, 0);
    wait_for("t5_done_to", 1, 200);
    chk("t5_count", pix5, 4096);
    chk("t5_bad", bad5, 0);
    chk("t5_err", {err_seen, err5}, {CHK, CHK});
    chk("t5_err_at", err_cv, CHK ? {16'd32, 16'd0, 16'd0} : 48'd0);

    // T2: out_ready toggling
    clr_mon();
    tog = 1'b1;
    pulse_start();
    wait_for("t2_done_to", 0, 12000);
    tog = 1'b0;
    repeat (3) @(posedge clk);
    chk("t2_count", pix, 4096);
    chk("t2_bad", bad, 0);
    chk("t2_hold", hold_bad, 0);
    chk("t2_outst", max_out, 2);

    // T3: delayed small sweep
    first = -1;
    first_ov = -1;
    nout = 0;
    bad3 = 0;
    done3_n = 0;
    done_k = -1;
    seq = '0;
    @(negedge clk);
    start3 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 0) start3 = 1'b0;
      if (read_ren3) begin
        if (first < 0) first = k;
        seq = {seq[27:0], bren3};
      end
      if (ov3) begin
        if (first_ov < 0) first_ov = k;
        if (od3 !== exp_px(nout, 4, 64, 1'b0)) bad3++;
        nout++;
      end
      if (done3) begin
        done3_n++;
        done_k = k;
      end
    end
    chk("t3_first_ren", first, 5);
    chk("t3_bank_seq", seq, 32'h1212_4848);
    chk("t3_first_ov", first_ov, 7);
    chk("t3_nout", nout, 8);
    chk("t3_bad", bad3, 0);
    chk("t3_done", {done3_n, done_k}, {32'd1, 32'd16});

    // T4: flush mid-sweep, then replay
    clr_mon();
    pulse_start();
    for (int n = 0; n < 400 && pix < 100; n++) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t4_after_flush", {read_ren, out_valid, bren}, 0);
    p0 = pix;
    repeat (30) @(posedge clk);
    chk("t4_no_out", pix, p0);
    chk("t4_no_done", done_n, 0);
    clr_mon();
    pulse_start();
    wait_for("t4_done_to", 0, 6000);
    repeat (3) @(posedge clk);
    chk("t4_count", pix, 4096);
    chk("t4_bad", bad, 0);

    // T6: async reset mid-sweep
    clr_mon();
    pulse_start();
    repeat (300) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {read_ren, bren, out_valid, done, err}, 0);
    chk("t6_rst_data", od, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    pulse_start();
    wait_for("t6_done_to", 0, 6000);
    repeat (3) @(posedge clk);
    chk("t6_count", pix, 4096);
    chk("t6_bad", bad, 0);
    chk("t6_done_n", done_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
